rf_wb_scoreboard: RTL and testbench

- Controls the register file write port and issue hazards for the single-issue pipeline.
- Keeps one pending bit per architectural register for writes issued but not yet committed.
- Stalls issue on RAW and WAW hazards.
- Arbitrates the register file write port between the fast pipe (ALU, cannot stall) and the slow unit (load/multiply, valid/ready).
- Drives the register file WEN/wsel/wdat from a registered stage.

---
 rtl/rf_wb_scoreboard_pkg.sv | 25 ++
 rtl/rf_wb_arbiter.sv | 80 ++++++++
 rtl/rf_wb_scoreboard.sv | 94 +++++++++
 tb/tb_rf_wb_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared types and constants for the register file writeback scoreboard.
package rf_wb_scoreboard_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    // Source latched into the register file write stage.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_FAST = 2'd1,
        WB_SLOW = 2'd2
    } wb_src_t;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int SCNT_W_DEFAULT     = 3;

    // One-hot mask for an architectural register; register 0 never gets a bit.
    function automatic logic [31:0] reg_mask(input regbits_t r);
        logic [31:0] m;
        m    = 32'd1 << r;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter.sv
// Writeback port arbiter: fast pipe has absolute priority, the slow unit uses
// valid/ready. Also owns the starvation counter and the registered write stage.
// The starvation counter needs 2^SCNT_W > STARVE_MAX so it can reach the limit.
module rf_wb_arbiter
    import rf_wb_scoreboard_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int SCNT_W     = SCNT_W_DEFAULT
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     a_valid,
    input  regbits_t a_sel,
    input  word_t    a_dat,
    input  logic     b_valid,
    input  regbits_t b_sel,
    input  word_t    b_dat,
    output logic     b_ready,
    output logic     acc_valid,
    output regbits_t acc_sel,
    output logic     starve_stall,
    output wb_src_t  wb_src,
    output regbits_t wb_sel,
    output word_t    wb_dat
);

    logic [SCNT_W-1:0] scnt;
    word_t             acc_dat;

    // Grant: the fast pipe cannot stall, so the slow unit only wins idle cycles.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        b_ready   = 1'b0;
        acc_valid = 1'b0;
        acc_sel   = '0;
        acc_dat   = '0;
        if (a_valid) begin
            acc_valid = 1'b1;
            acc_sel   = a_sel;
            acc_dat   = a_dat;
        end else if (b_valid) begin
            b_ready   = 1'b1;
            acc_valid = 1'b1;
            acc_sel   = b_sel;
            acc_dat   = b_dat;
        end
    end

    assign starve_stall = (scnt >= SCNT_W'(STARVE_MAX));

    // Count consecutive cycles the slow unit waits; saturate, clear on grant or idle.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!nRST) begin
            scnt <= '0;
        end else if (b_valid && !b_ready) begin
            if (scnt != '1) begin
                scnt <= scnt + 1'b1;
            end
        end else begin
            scnt <= '0;
        end
    end

    // Output stage: latch the granted write; writes to register 0 are dropped here.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_src <= WB_NONE;
            wb_sel <= '0;
            wb_dat <= '0;
        end else if (acc_valid && (acc_sel != '0)) begin
            wb_src <= a_valid ? WB_FAST : WB_SLOW;
            wb_sel <= acc_sel;
            wb_dat <= acc_dat;
        end else begin
            wb_src <= WB_NONE;
        end
    end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register file writeback scoreboard: pending-write tracking, RAW/WAW issue
// hazards, starvation stall and sticky writeback error around the arbiter.
module rf_wb_scoreboard
    import rf_wb_scoreboard_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int SCNT_W     = SCNT_W_DEFAULT
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     issue_valid,
    input  regbits_t issue_rs,
    input  regbits_t issue_rt,
    input  regbits_t issue_rd,
    input  logic     issue_wen,
    output logic     issue_stall,
    input  logic     a_valid,
    input  regbits_t a_sel,
    input  word_t    a_dat,
    input  logic     b_valid,
    input  regbits_t b_sel,
    input  word_t    b_dat,
    output logic     b_ready,
    output logic     rf_wen,
    output regbits_t rf_wsel,
    output word_t    rf_wdat,
    output logic     wb_err
);

    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        acc_valid;
    regbits_t    acc_sel;
    logic        starve_stall;
    logic        issue_accept;
    logic        haz_rs;
    logic        haz_rt;
    logic        haz_rd;
    wb_src_t     wb_src;

    rf_wb_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .SCNT_W     (SCNT_W)
    ) u_arb (
        .CLK          (CLK),
        .nRST         (nRST),
        .a_valid      (a_valid),
        .a_sel        (a_sel),
        .a_dat        (a_dat),
        .b_valid      (b_valid),
        .b_sel        (b_sel),
        .b_dat        (b_dat),
        .b_ready      (b_ready),
        .acc_valid    (acc_valid),
        .acc_sel      (acc_sel),
        .starve_stall (starve_stall),
        .wb_src       (wb_src),
        .wb_sel       (rf_wsel),
        .wb_dat       (rf_wdat)
    );

    assign rf_wen = (wb_src != WB_NONE);

    // Hazard detect against the pending vector; no bypass of this cycle's clear.
    always_comb begin
        haz_rs       = (issue_rs != '0) && pending[issue_rs];
        haz_rt       = (issue_rt != '0) && pending[issue_rt];
        haz_rd       = issue_wen && (issue_rd != '0) && pending[issue_rd];
        issue_stall  = issue_valid && (haz_rs || haz_rt || haz_rd || starve_stall);
        issue_accept = issue_valid && !issue_stall;
        set_mask     = (issue_accept && issue_wen) ? reg_mask(issue_rd) : '0;
        clr_mask     = rf_wen ? reg_mask(rf_wsel) : '0;
    end

    // Pending bits: set on issue, cleared on the edge that commits the write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Sticky error: an accepted writeback whose register was never marked pending.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_err <= 1'b0;
        end else if (acc_valid && (acc_sel != '0) && !pending[acc_sel]) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Self-checking bench for rf_wb_scoreboard: directed hazard/arbitration cases
// with a writeback scoreboard comparing every register file write.
module tb_rf_wb_scoreboard;

    logic        CLK;
    logic        nRST;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic        issue_stall;
    logic        a_valid;
    logic [4:0]  a_sel;
    logic [31:0] a_dat;
    logic        b_valid;
    logic [4:0]  b_sel;
    logic [31:0] b_dat;
    logic        b_ready;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        wb_err;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    rf_wb_scoreboard dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .issue_valid (issue_valid),
        .issue_rs    (issue_rs),
        .issue_rt    (issue_rt),
        .issue_rd    (issue_rd),
        .issue_wen   (issue_wen),
        .issue_stall (issue_stall),
        .a_valid     (a_valid),
        .a_sel       (a_sel),
        .a_dat       (a_dat),
        .b_valid     (b_valid),
        .b_sel       (b_sel),
        .b_dat       (b_dat),
        .b_ready     (b_ready),
        .rf_wen      (rf_wen),
        .rf_wsel     (rf_wsel),
        .rf_wdat     (rf_wdat),
        .wb_err      (wb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic wen);
        issue_valid = v;
        issue_rs    = rs;
        issue_rt    = rt;
        issue_rd    = rd;
        issue_wen   = wen;
    endtask

    task automatic fast(input logic v, input logic [4:0] sel, input logic [31:0] dat);
        a_valid = v;
        a_sel   = sel;
        a_dat   = dat;
    endtask

    task automatic slow(input logic v, input logic [4:0] sel, input logic [31:0] dat);
        b_valid = v;
        b_sel   = sel;
        b_dat   = dat;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        fast(1'b0, 5'd0, 32'd0);
        slow(1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] sel, input logic [31:0] dat);
        wr_t e;
        e.sel = sel;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every register file write must match the oldest expected write.
    always @(negedge CLK) begin
        if (nRST && rf_wen) begin
            if (exp_q.size() == 0) begin
                check("wb_spurious", 32'(rf_wen), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_sel", 32'(rf_wsel), 32'(mon_e.sel));
                check("wb_dat", rf_wdat, mon_e.dat);
            end
        end
    end

    initial begin
        nRST = 1'b0;
        idle();
        #2;
        check("rst_stall", 32'(issue_stall), 32'd0);
        check("rst_bready", 32'(b_ready), 32'd0);
        check("rst_wen", 32'(rf_wen), 32'd0);
        check("rst_wsel", 32'(rf_wsel), 32'd0);
        check("rst_wdat", rf_wdat, 32'd0);
        check("rst_err", 32'(wb_err), 32'd0);
        #10;
        nRST = 1'b1;
        tick();

        // RAW on a fast-pipe result
        issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        settle();
        check("issue_rd5", 32'(issue_stall), 32'd0);
        tick();
        issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        fast(1'b1, 5'd5, 32'hDEAD);
        expect_wr(5'd5, 32'hDEAD);
        settle();
        check("raw_rs5", 32'(issue_stall), 32'd1);
        tick();
        fast(1'b0, 5'd0, 32'd0);
        settle();
        check("raw_hold", 32'(issue_stall), 32'd1);
        check("t1_wen", 32'(rf_wen), 32'd1);
        tick();
        settle();
        check("raw_release", 32'(issue_stall), 32'd0);
        check("t1_wen_off", 32'(rf_wen), 32'd0);
        tick();
        idle();

        // Fast beats slow in the same cycle; slow goes next idle cycle
        issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd8, 1'b1);
        tick();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        fast(1'b1, 5'd8, 32'h8888);
        slow(1'b1, 5'd7, 32'h1234);
        expect_wr(5'd8, 32'h8888);
        settle();
        check("arb_b_blocked", 32'(b_ready), 32'd0);
        tick();
        fast(1'b0, 5'd0, 32'd0);
        expect_wr(5'd7, 32'h1234);
        settle();
        check("arb_b_granted", 32'(b_ready), 32'd1);
        check("arb_fast_first", 32'(rf_wsel), 32'd8);
        tick();
        slow(1'b0, 5'd0, 32'd0);
        settle();
        check("arb_slow_wen", 32'(rf_wen), 32'd1);
        check("arb_slow_sel", 32'(rf_wsel), 32'd7);
        tick();
        settle();
        check("arb_idle_wen", 32'(rf_wen), 32'd0);

        // Starvation: slow waits four cycles, then issue stalls regardless of operands
        for (int r = 10; r <= 15; r++) begin
            issue(1'b1, 5'd0, 5'd0, 5'(r), 1'b1);
            tick();
        end
        issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            fast(1'b1, 5'(9 + j), 32'hA000 + 32'(j));
            slow(1'b1, 5'd15, 32'h5555);
            expect_wr(5'(9 + j), 32'hA000 + 32'(j));
            settle();
            check($sformatf("starve_c%0d", j), 32'(issue_stall), (j >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        fast(1'b0, 5'd0, 32'd0);
        expect_wr(5'd15, 32'h5555);
        settle();
        check("starve_grant", 32'(b_ready), 32'd1);
        check("starve_hold", 32'(issue_stall), 32'd1);
        tick();
        slow(1'b0, 5'd0, 32'd0);
        settle();
        check("starve_clear", 32'(issue_stall), 32'd0);
        tick();
        idle();
        tick();

        // Register 0: never pending, never hazards, writes discarded
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        settle();
        check("r0_issue", 32'(issue_stall), 32'd0);
        tick();
        fast(1'b1, 5'd0, 32'hFFFF);
        settle();
        check("r0_read", 32'(issue_stall), 32'd0);
        tick();
        idle();
        settle();
        check("r0_no_wen", 32'(rf_wen), 32'd0);
        check("r0_no_err", 32'(wb_err), 32'd0);
        tick();

        // Writeback to a non-pending register, then WAW
        fast(1'b1, 5'd9, 32'h9999);
        expect_wr(5'd9, 32'h9999);
        settle();
        check("err_before", 32'(wb_err), 32'd0);
        tick();
        fast(1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        settle();
        check("err_set", 32'(wb_err), 32'd1);
        check("waw_first", 32'(issue_stall), 32'd0);
        tick();
        fast(1'b1, 5'd3, 32'h3333);
        expect_wr(5'd3, 32'h3333);
        settle();
        check("waw_stall", 32'(issue_stall), 32'd1);
        tick();
        fast(1'b0, 5'd0, 32'd0);
        settle();
        check("waw_hold", 32'(issue_stall), 32'd1);
        tick();
        settle();
        check("waw_release", 32'(issue_stall), 32'd0);
        tick();
        idle();
        settle();
        check("err_sticky", 32'(wb_err), 32'd1);

        // Asynchronous reset with a write in flight
        issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
        tick();
        idle();
        fast(1'b1, 5'd4, 32'h4444);
        tick();
        fast(1'b0, 5'd0, 32'd0);
        settle();
        check("rst_inflight", 32'(rf_wen), 32'd1);
        #1;
        nRST = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_wen", 32'(rf_wen), 32'd0);
        check("rst_async_err", 32'(wb_err), 32'd0);
        tick();
        #3;
        nRST = 1'b1;
        tick();
        settle();
        check("rst_no_write", 32'(rf_wen), 32'd0);
        issue(1'b1, 5'd6, 5'd4, 5'd0, 1'b0);
        settle();
        check("rst_pending_clr", 32'(issue_stall), 32'd0);
        tick();
        idle();
        tick();
        tick();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
